// File: rtl/logic_sweep_checker.sv
// rtl/logic_sweep_checker.sv - truth-table function with live output and exhaustive on-chip sweep checker
//
// Purpose:
//   Holds an N_IN-input Boolean function as a truth-table mask. The live path
//   registers FUNC_MASK[in_vec_i] every cycle. The sweep engine presents every
//   input vector 0..2^N_IN-1 to an external implementation of the function,
//   samples each response DUT_LAT cycles later, and either compares it against
//   the mask (mode 0) or only counts ones (mode 1).
//
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   in_vec_i           live-mode input vector (MSB = first variable)
//   live_out_o         registered FUNC_MASK[in_vec_i]
//   start_i            begin a sweep, honoured only in IDLE
//   mode_i             0 = compare, 1 = count-only, captured with start
//   sweep_vec_o        vector driven to the external function
//   sweep_valid_o      sweep_vec_o is presented this cycle
//   dut_out_i          external function response
//   busy_o             sweep (including drain) in progress
//   done_o             one-cycle completion pulse
//   pass_o             compare mode and no mismatches
//   err_count_o        mismatch count
//   first_err_vec_o    vector of the first mismatch
//   first_err_valid_o  at least one mismatch recorded
//   ones_count_o       number of sampled responses equal to 1

module logic_sweep_checker #(
  parameter int                     N_IN      = 4,
  parameter logic [(1<<N_IN)-1:0]   FUNC_MASK = 16'hAAE0,
  parameter int                     DUT_LAT   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_IN-1:0]   in_vec_i,
  output logic              live_out_o,
  input  logic              start_i,
  input  logic              mode_i,
  output logic [N_IN-1:0]   sweep_vec_o,
  output logic              sweep_valid_o,
  input  logic              dut_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [N_IN:0]     err_count_o,
  output logic [N_IN-1:0]   first_err_vec_o,
  output logic              first_err_valid_o,
  output logic [N_IN:0]     ones_count_o
);

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q;
  logic              live_out_q;
  logic              mode_q;
  logic [N_IN-1:0]   sweep_vec_q;
  logic              sweep_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_IN:0]     err_count_q;
  logic [N_IN-1:0]   first_err_vec_q;
  logic              first_err_valid_q;
  logic [N_IN:0]     ones_count_q;
  logic [1:0]        drain_cnt_q;

  // Sample tap: the {valid, vector, expected} tuple whose response is on
  // dut_out_i in the current cycle.
  logic              samp_valid;
  logic [N_IN-1:0]   samp_vec;
  logic              samp_exp;

  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign samp_valid = sweep_valid_q;
      assign samp_vec   = sweep_vec_q;
      assign samp_exp   = FUNC_MASK[sweep_vec_q];
    end else begin : g_lat
      logic [DUT_LAT-1:0] dl_valid_q;
      logic [DUT_LAT-1:0] dl_exp_q;
      logic [N_IN-1:0]    dl_vec_q [DUT_LAT];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          dl_valid_q <= '0;
          dl_exp_q   <= '0;
          for (int i = 0; i < DUT_LAT; i++) begin
            dl_vec_q[i] <= '0;
          end
        end else begin
          dl_valid_q[0] <= sweep_valid_q;
          dl_exp_q[0]   <= FUNC_MASK[sweep_vec_q];
          dl_vec_q[0]   <= sweep_vec_q;
          for (int i = 1; i < DUT_LAT; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_exp_q[i]   <= dl_exp_q[i-1];
            dl_vec_q[i]   <= dl_vec_q[i-1];
          end
        end
      end

      assign samp_valid = dl_valid_q[DUT_LAT-1];
      assign samp_vec   = dl_vec_q[DUT_LAT-1];
      assign samp_exp   = dl_exp_q[DUT_LAT-1];
    end
  endgenerate

  logic              mism;
  logic [N_IN:0]     err_count_d;
  logic [N_IN:0]     ones_count_d;

  assign mism         = samp_valid && !mode_q && (dut_out_i != samp_exp);
  assign err_count_d  = err_count_q + (N_IN+1)'(mism);
  assign ones_count_d = ones_count_q + (N_IN+1)'(samp_valid && dut_out_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= S_IDLE;
      live_out_q        <= 1'b0;
      mode_q            <= 1'b0;
      sweep_vec_q       <= '0;
      sweep_valid_q     <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      ones_count_q      <= '0;
      drain_cnt_q       <= '0;
    end else begin
      live_out_q   <= FUNC_MASK[in_vec_i];
      err_count_q  <= err_count_d;
      ones_count_q <= ones_count_d;
      if (mism && !first_err_valid_q) begin
        first_err_valid_q <= 1'b1;
        first_err_vec_q   <= samp_vec;
      end

      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            // Later assignments win, so these clears override the
            // accumulation above on the accepting edge.
            state_q           <= S_SWEEP;
            mode_q            <= mode_i;
            busy_q            <= 1'b1;
            sweep_valid_q     <= 1'b1;
            sweep_vec_q       <= '0;
            err_count_q       <= '0;
            ones_count_q      <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            pass_q            <= 1'b0;
          end
        end

        S_SWEEP: begin
          if (sweep_vec_q == LAST_VEC) begin
            // Counter parks on the last vector rather than wrapping.
            sweep_valid_q <= 1'b0;
            drain_cnt_q   <= '0;
            if (DUT_LAT == 0) begin
              // Final response is sampled this cycle, so pass uses the
              // next-state error count.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !mode_q && (err_count_d == '0);
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            sweep_vec_q <= sweep_vec_q + 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_cnt_q == 2'(DUT_LAT - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mode_q && (err_count_d == '0);
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign live_out_o        = live_out_q;
  assign sweep_vec_o       = sweep_vec_q;
  assign sweep_valid_o     = sweep_valid_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_count_q;
  assign first_err_vec_o   = first_err_vec_q;
  assign first_err_valid_o = first_err_valid_q;
  assign ones_count_o      = ones_count_q;

endmodule

// File: doc/logic_sweep_checker.md
# logic_sweep_checker

Parametrised successor to the team's fixed 4-input gate-level function blocks and their hand-written exhaustive stimulus benches. It evaluates an N-input Boolean function defined by a truth-table mask parameter, with a registered live output. It also contains a sequential sweep engine that drives all 2^N input vectors to an external function implementation, compares each response against the mask (or counts ones), and reports the pass/fail status, mismatch count and first failing vector. It sits beside any combinational or pipelined function block as an on-chip self-checker.

## Interface
- N_IN, 4, number of function inputs; legal range 1..8; in_vec[N_IN-1] is the MSB (A in A,B,C,D ordering).
- FUNC_MASK, 16'hAAE0, 2^N_IN-bit truth table; bit i is the expected output for input vector i. The default encodes (A|B)&(~B|C|D)&(~A|D).
- DUT_LAT, 0, external function latency in cycles; legal range 0..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vec  in  N_IN  live-mode input vector.
- live_out  out  1  registered FUNC_MASK[in_vec].
- start  in  1  begins a sweep; sampled only in IDLE.
- mode  in  1  0 = compare, 1 = count-only; captured when start is accepted.
- sweep_vec  out  N_IN  vector driven to the external function.
- sweep_valid  out  1  sweep_vec is being presented this cycle.
- dut_out  in  1  external function response.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  compare-mode result; err_count==0.
- err_count  out  N_IN+1  number of mismatches.
- first_err_vec  out  N_IN  vector of the first mismatch.
- first_err_valid  out  1  at least one mismatch has been recorded.
- ones_count  out  N_IN+1  number of sampled dut_out==1 responses.

## Operation
- Live path: live_out <= FUNC_MASK[in_vec] every cycle, in every state.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: when start=1, capture mode and go to SWEEP. On acceptance, clear err_count, first_err_vec, first_err_valid, ones_count and pass.
- SWEEP: present vector k = 0, 1, ..., 2^N_IN-1, one per cycle, with sweep_valid=1.
  - After the last vector, go to DRAIN if DUT_LAT>0; otherwise go to DONE.
- DRAIN: hold for DUT_LAT cycles while sweep_valid=0, then go to DONE.
- DONE: pulse done for one cycle, set pass = (mode==0 && err_count==0), then return to IDLE.
- Delay line: a DUT_LAT-deep shift register carries {valid, vector, expected bit}. The response to vector k is sampled DUT_LAT cycles after k is presented; with DUT_LAT=0 it is sampled in the same cycle.
- On each sampled response:
  - ones_count increments if dut_out=1, in both modes.
  - In compare mode, if dut_out != expected, err_count increments. On the first mismatch only, load first_err_vec and set first_err_valid.
- Count-only mode: err_count stays 0 and pass stays 0.
- Width rules:
  - err_count and ones_count max out at exactly 2^N_IN, so no saturation is needed.
  - The vector counter stops at 2^N_IN-1 and does not wrap.
- start while busy or in DONE: ignored.
- Results hold until the next accepted start.
- Reset assertion at any time, including mid-sweep: all state and outputs go to 0 immediately and the FSM goes to IDLE. No partial results are retained.
- Reset values: live_out=0, sweep_vec=0, sweep_valid=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, ones_count=0.

## Timing
- start accepted at rising edge T. busy=1, sweep_valid=1 and sweep_vec=0 from T+1.
- Vector k is presented in cycle T+1+k. Its response is sampled in cycle T+1+k+DUT_LAT.
- busy is high from T+1 through T+2^N_IN+DUT_LAT inclusive, i.e. 2^N_IN+DUT_LAT cycles.
- done=1 in cycle T+2^N_IN+DUT_LAT+1 with busy=0. All results are final in that cycle.
- The earliest next start accepted is in the cycle after done.
- live_out has 1-cycle latency from in_vec.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, then in_vec=4'b0101 -> live_out=1 one cycle later; in_vec=4'b1000 -> live_out=0.
- Clean compare, defaults, dut_out from a correct combinational model, start at T -> done at T+17, pass=1, err_count=0, first_err_valid=0, ones_count=7.
- Single fault: model inverted only at vector 4'b0110 -> err_count=1, first_err_vec=6, first_err_valid=1, pass=0, ones_count=6.
- DUT_LAT=2 with a 2-stage registered correct model -> busy for 18 cycles, done at T+19, pass=1. The unregistered model with DUT_LAT=2 -> err_count>0, pass=0.
- Count-only mode with dut_out tied 1 -> ones_count=16, err_count=0, pass=0. A start pulse mid-sweep -> ignored, with exactly 16 vectors presented.
- rst_n pulsed low while sweep_vec=9 -> outputs 0 asynchronously, FSM in IDLE. A new start -> full 16-vector sweep from vector 0 with correct results.
